// File: rtl/sequenciador_mapas_pkg.sv
// Shared types for the sensor-reading sequencer that feeds the mapas grid updater.
// Holds the FSM state encoding, the buffered reading record and counter helpers.
package mapas_pkg;

  localparam int TAMANHO_DISTANCIA = 4;
  localparam int LARGURA_CONTADOR  = 16;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    ENVIA       = 2'd1,
    AGUARDA_FIM = 2'd2,
    CONCLUI     = 2'd3
  } estado_seq_t;

  typedef struct packed {
    logic [TAMANHO_DISTANCIA-1:0] x;
    logic [TAMANHO_DISTANCIA-1:0] y;
    logic                         direcao;
    logic [TAMANHO_DISTANCIA-1:0] frente;
    logic [TAMANHO_DISTANCIA-1:0] direita;
    logic [TAMANHO_DISTANCIA-1:0] esquerda;
  } leitura_t;

  // Progress counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [LARGURA_CONTADOR-1:0] incrementa_saturado(
    input logic [LARGURA_CONTADOR-1:0] valor
  );
    logic [LARGURA_CONTADOR-1:0] resultado;
    if (valor == 16'hFFFF) begin
      resultado = valor;
    end else begin
      resultado = valor + 16'd1;
    end
    return resultado;
  endfunction

endpackage

// File: rtl/sequenciador_mapas_if.sv
// Reading bus from the navigation front end plus the novoDado/operacaoFinalizada
// link to mapas; slave is the sequencer side, master the surrounding environment.
interface sequenciador_mapas_if;
  import mapas_pkg::*;

  logic                         leituraValida;
  logic                         leituraPronta;
  logic [TAMANHO_DISTANCIA-1:0] entradaX;
  logic [TAMANHO_DISTANCIA-1:0] entradaY;
  logic                         entradaDirecao;
  logic [TAMANHO_DISTANCIA-1:0] entradaFrente;
  logic [TAMANHO_DISTANCIA-1:0] entradaDireita;
  logic [TAMANHO_DISTANCIA-1:0] entradaEsquerda;

  logic [TAMANHO_DISTANCIA-1:0] posicaoAtualnoEixoX;
  logic [TAMANHO_DISTANCIA-1:0] posicaoAtualnoEixoY;
  logic                         direcaoAtual;
  logic [TAMANHO_DISTANCIA-1:0] distanciaFrente;
  logic [TAMANHO_DISTANCIA-1:0] distanciaDireita;
  logic [TAMANHO_DISTANCIA-1:0] distanciaEsquerda;
  logic                         novoDado;
  logic                         operacaoFinalizada;

  modport slave (
    input  leituraValida, entradaX, entradaY, entradaDirecao,
           entradaFrente, entradaDireita, entradaEsquerda, operacaoFinalizada,
    output leituraPronta, posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
           distanciaFrente, distanciaDireita, distanciaEsquerda, novoDado
  );

  modport master (
    output leituraValida, entradaX, entradaY, entradaDirecao,
           entradaFrente, entradaDireita, entradaEsquerda, operacaoFinalizada,
    input  leituraPronta, posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
           distanciaFrente, distanciaDireita, distanciaEsquerda, novoDado
  );

endinterface

// File: rtl/sequenciador_mapas_fila.sv
// Synchronous FIFO of sensor readings; head is read combinationally, pointers wrap
// naturally because the depth is a power of two.
module fila_leituras
  import mapas_pkg::*;
#(
  parameter int Profundidade = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  leitura_t                    dado_entrada,
  output leitura_t                    dado_saida,
  output logic                        cheia,
  output logic                        vazia,
  output logic [$clog2(Profundidade):0] count
);

  localparam int             PW   = $clog2(Profundidade);
  localparam logic [PW:0]    PROF = (PW+1)'(Profundidade);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  leitura_t      mem_q [Profundidade];
  leitura_t      mem_d [Profundidade];
  logic          push_ok_s;
  logic          pop_ok_s;

  // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    push_ok_s = push && (count_q < PROF);
    pop_ok_s  = pop && (count_q != (PW+1)'(0));
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = dado_entrada;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + (PW+1)'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - (PW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Control registers; clearing the pointers discards whatever was queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign dado_saida = mem_q[rd_ptr_q];
  assign cheia      = (count_q == PROF);
  assign vazia      = (count_q == (PW+1)'(0));
  assign count      = count_q;

endmodule

// File: rtl/sequenciador_mapas.sv
// Pops buffered sensor readings one at a time and hands each to mapas through the
// novoDado/operacaoFinalizada handshake, with discard, progress and timeout reporting.
module sequenciador_mapas
  import mapas_pkg::*;
#(
  parameter int TamanhoMalha     = 8,
  parameter int ProfundidadeFila = 4,
  parameter int LimiteEspera     = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  sequenciador_mapas_if.slave         bus,
  output logic                        ocupado,
  output logic [LARGURA_CONTADOR-1:0] contadorLeituras,
  output logic [LARGURA_CONTADOR-1:0] contadorDescartes,
  output logic                        erroTimeout
);

  localparam int tamanhoDistancia = TAMANHO_DISTANCIA;
  localparam int PW = $clog2(ProfundidadeFila);
  localparam int EW = $clog2(LimiteEspera + 1);
  localparam logic [PW:0]    PROF      = (PW+1)'(ProfundidadeFila);
  localparam logic [EW-1:0]  LIMITE_M1 = EW'(LimiteEspera - 1);
  // A grid as wide as the coordinate field makes every coordinate legal.
  localparam bit DESCARTE_POSSIVEL = (TamanhoMalha < (1 << tamanhoDistancia));
  localparam logic [tamanhoDistancia-1:0] MALHA_W =
    DESCARTE_POSSIVEL ? tamanhoDistancia'(TamanhoMalha) : {tamanhoDistancia{1'b1}};

  estado_seq_t                 estado_q, estado_d;
  logic [EW-1:0]               espera_q, espera_d;
  leitura_t                    saida_q, saida_d;
  logic                        novo_dado_q, novo_dado_d;
  logic                        ocupado_q, ocupado_d;
  logic                        erro_q, erro_d;
  logic [LARGURA_CONTADOR-1:0] cont_leit_q, cont_leit_d;
  logic [LARGURA_CONTADOR-1:0] cont_desc_q, cont_desc_d;

  leitura_t      entrada_s;
  leitura_t      cabeca_s;
  logic          push_s;
  logic          pop_s;
  logic          cheia_s;
  logic          vazia_s;
  logic [PW:0]   count_s;
  logic          fora_s;

  assign entrada_s = '{x:        bus.entradaX,
                       y:        bus.entradaY,
                       direcao:  bus.entradaDirecao,
                       frente:   bus.entradaFrente,
                       direita:  bus.entradaDireita,
                       esquerda: bus.entradaEsquerda};
  assign push_s = bus.leituraValida && !cheia_s;

  fila_leituras #(
    .Profundidade (ProfundidadeFila)
  ) u_fila (
    .clock        (clock),
    .reset        (reset),
    .push         (push_s),
    .pop          (pop_s),
    .dado_entrada (entrada_s),
    .dado_saida   (cabeca_s),
    .cheia        (cheia_s),
    .vazia        (vazia_s),
    .count        (count_s)
  );

  // Unsigned range check of the head reading against the grid size.
  always_comb begin
    if (DESCARTE_POSSIVEL) begin
      fora_s = (cabeca_s.x >= MALHA_W) || (cabeca_s.y >= MALHA_W);
    end else begin
      fora_s = 1'b0;
    end
  end

  // Sequencer next state, wait counter, counters and output field capture.
  always_comb begin
    estado_d    = estado_q;
    espera_d    = espera_q;
    saida_d     = saida_q;
    erro_d      = erro_q;
    cont_leit_d = cont_leit_q;
    cont_desc_d = cont_desc_q;
    pop_s       = 1'b0;
    case (estado_q)
      OCIOSO: begin
        espera_d = '0;
        if (!vazia_s) begin
          pop_s = 1'b1;
          if (fora_s) begin
            cont_desc_d = incrementa_saturado(cont_desc_q);
          end else begin
            saida_d  = cabeca_s;
            estado_d = ENVIA;
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      ENVIA: begin
        if (!bus.operacaoFinalizada) begin
          estado_d = AGUARDA_FIM;
          espera_d = '0;
        end else if (espera_q == LIMITE_M1) begin
          erro_d   = 1'b1;
          estado_d = CONCLUI;
          espera_d = '0;
        end else begin
          espera_d = espera_q + EW'(1);
        end
      end
      AGUARDA_FIM: begin
        // Completion is checked first so it wins over a coinciding timeout.
        if (bus.operacaoFinalizada) begin
          cont_leit_d = incrementa_saturado(cont_leit_q);
          estado_d    = CONCLUI;
          espera_d    = '0;
        end else if (espera_q == LIMITE_M1) begin
          erro_d   = 1'b1;
          estado_d = CONCLUI;
          espera_d = '0;
        end else begin
          espera_d = espera_q + EW'(1);
        end
      end
      CONCLUI: begin
        estado_d = OCIOSO;
        espera_d = '0;
      end
      default: begin
        estado_d = OCIOSO;
        espera_d = '0;
      end
    endcase
    // Request rises one cycle after the pop and falls on entry to CONCLUI.
    novo_dado_d = (estado_q != OCIOSO) &&
                  ((estado_d == ENVIA) || (estado_d == AGUARDA_FIM));
    ocupado_d   = (estado_d != OCIOSO);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      espera_q    <= '0;
      saida_q     <= '0;
      novo_dado_q <= 1'b0;
      ocupado_q   <= 1'b0;
      erro_q      <= 1'b0;
      cont_leit_q <= '0;
      cont_desc_q <= '0;
    end else begin
      estado_q    <= estado_d;
      espera_q    <= espera_d;
      saida_q     <= saida_d;
      novo_dado_q <= novo_dado_d;
      ocupado_q   <= ocupado_d;
      erro_q      <= erro_d;
      cont_leit_q <= cont_leit_d;
      cont_desc_q <= cont_desc_d;
    end
  end

  assign bus.leituraPronta       = (count_s < PROF);
  assign bus.posicaoAtualnoEixoX = saida_q.x;
  assign bus.posicaoAtualnoEixoY = saida_q.y;
  assign bus.direcaoAtual        = saida_q.direcao;
  assign bus.distanciaFrente     = saida_q.frente;
  assign bus.distanciaDireita    = saida_q.direita;
  assign bus.distanciaEsquerda   = saida_q.esquerda;
  assign bus.novoDado            = novo_dado_q;
  assign ocupado                 = ocupado_q;
  assign contadorLeituras        = cont_leit_q;
  assign contadorDescartes       = cont_desc_q;
  assign erroTimeout             = erro_q;

endmodule

// File: tb/tb_sequenciador_mapas.sv
// Scoreboard bench: each delivered reading is queued when issued and checked by a
// monitor on every rising novoDado; a small mapas model answers the handshake.
module tb_sequenciador_mapas;
  import mapas_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ocupado;
  logic [15:0] contadorLeituras;
  logic [15:0] contadorDescartes;
  logic        erroTimeout;

  int       n_vec = 0;
  int       n_err = 0;
  leitura_t exp_q[$];
  bit       trava = 1'b0;
  bit       pronta_baixa = 1'b0;
  int       leit_esp = 0;

  always #5 clock = ~clock;

  sequenciador_mapas_if bus();

  sequenciador_mapas #(
    .TamanhoMalha     (8),
    .ProfundidadeFila (4),
    .LimiteEspera     (20)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .ocupado           (ocupado),
    .contadorLeituras  (contadorLeituras),
    .contadorDescartes (contadorDescartes),
    .erroTimeout       (erroTimeout)
  );

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  function automatic leitura_t mk(input int x, input int y, input int d,
                                  input int f, input int r, input int l);
    leitura_t v;
    v.x = 4'(x); v.y = 4'(y); v.direcao = 1'(d);
    v.frente = 4'(f); v.direita = 4'(r); v.esquerda = 4'(l);
    return v;
  endfunction

  function automatic leitura_t saida_atual();
    leitura_t v;
    v.x = bus.posicaoAtualnoEixoX; v.y = bus.posicaoAtualnoEixoY;
    v.direcao = bus.direcaoAtual; v.frente = bus.distanciaFrente;
    v.direita = bus.distanciaDireita; v.esquerda = bus.distanciaEsquerda;
    return v;
  endfunction

  task automatic envia(input leitura_t l, input bit entregue);
    int esp = 0;
    @(negedge clock);
    bus.leituraValida  = 1'b1;
    bus.entradaX       = l.x;       bus.entradaY       = l.y;
    bus.entradaDirecao = l.direcao; bus.entradaFrente  = l.frente;
    bus.entradaDireita = l.direita; bus.entradaEsquerda = l.esquerda;
    while (bus.leituraPronta !== 1'b1 && esp < 200) begin
      pronta_baixa = 1'b1;
      @(negedge clock);
      esp++;
    end
    chk("aceite", 32'(esp < 200), 32'd1);
    if (entregue) exp_q.push_back(l);
    @(posedge clock);
    #1 bus.leituraValida = 1'b0;
  endtask

  task automatic espera_ocioso(input string nome);
    int quietos = 0;
    int ciclos = 0;
    while (quietos < 6 && ciclos < 1000) begin
      @(negedge clock);
      ciclos++;
      if (ocupado === 1'b0) quietos++; else quietos = 0;
    end
    chk(nome, 32'(quietos >= 6), 32'd1);
  endtask

  // mapas model: idle high, drops finalizada 2 cycles after novoDado, raises it 5 later.
  initial begin
    bus.operacaoFinalizada = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.novoDado === 1'b1) begin
        repeat (2) @(posedge clock);
        #1 bus.operacaoFinalizada = 1'b0;
        if (!trava) begin
          repeat (5) @(posedge clock);
          #1 bus.operacaoFinalizada = 1'b1;
        end
        while (bus.novoDado !== 1'b0) @(negedge clock);
        bus.operacaoFinalizada = 1'b1;
      end
    end
  end

  // Monitor: every rising novoDado must present the oldest expected reading.
  initial begin
    logic nd_ant;
    nd_ant = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.novoDado === 1'b1 && nd_ant === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL entrega_inesperada: got %0h expected none", saida_atual());
        end else begin
          chk("entrega", 32'(saida_atual()), 32'(exp_q.pop_front()));
        end
      end
      nd_ant = bus.novoDado;
    end
  end

  initial begin
    int ciclos;
    int vistos;
    bus.leituraValida = 1'b0;
    bus.entradaX = 4'd0; bus.entradaY = 4'd0; bus.entradaDirecao = 1'b0;
    bus.entradaFrente = 4'd0; bus.entradaDireita = 4'd0; bus.entradaEsquerda = 4'd0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_novoDado", 32'(bus.novoDado), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_pronta", 32'(bus.leituraPronta), 32'd1);
    chk("reset_contadores", {contadorLeituras, contadorDescartes}, 32'd0);
    chk("reset_erro", 32'(erroTimeout), 32'd0);
    @(negedge clock) reset = 1'b0;

    // Single reading, latency of the request.
    envia(mk(3, 0, 1, 1, 2, 1), 1'b1);
    @(negedge clock);
    chk("lat_n0_novoDado", 32'(bus.novoDado), 32'd0);
    @(negedge clock);
    chk("lat_n1_novoDado", 32'(bus.novoDado), 32'd0);
    chk("lat_n1_ocupado", 32'(ocupado), 32'd1);
    @(negedge clock);
    chk("lat_n2_novoDado", 32'(bus.novoDado), 32'd1);
    espera_ocioso("ocioso_simples");
    leit_esp = 1;
    chk("simples_leituras", 32'(contadorLeituras), 32'(leit_esp));
    chk("simples_erro", 32'(erroTimeout), 32'd0);

    // Burst of six into a depth-4 FIFO, includes push+pop at count 1.
    pronta_baixa = 1'b0;
    envia(mk(1, 1, 0, 3, 4, 5), 1'b1);
    envia(mk(2, 3, 1, 6, 7, 8), 1'b1);
    envia(mk(4, 5, 0, 9, 10, 11), 1'b1);
    envia(mk(6, 7, 1, 12, 13, 14), 1'b1);
    envia(mk(0, 2, 0, 15, 0, 1), 1'b1);
    envia(mk(5, 4, 1, 2, 3, 4), 1'b1);
    espera_ocioso("ocioso_rajada");
    leit_esp += 6;
    chk("rajada_pronta_baixa", 32'(pronta_baixa), 32'd1);
    chk("rajada_leituras", 32'(contadorLeituras), 32'(leit_esp));

    // Out-of-range readings are dropped; boundary 7 is still legal.
    envia(mk(9, 2, 0, 1, 1, 1), 1'b0);
    envia(mk(7, 7, 1, 2, 2, 2), 1'b1);
    espera_ocioso("ocioso_descarte1");
    leit_esp += 1;
    chk("descarte_x9", 32'(contadorDescartes), 32'd1);
    envia(mk(2, 8, 1, 3, 3, 3), 1'b0);
    espera_ocioso("ocioso_descarte2");
    chk("descarte_y8", 32'(contadorDescartes), 32'd2);
    chk("descarte_leituras", 32'(contadorLeituras), 32'(leit_esp));

    // mapas never finishes: timeout after 20 cycles in AGUARDA_FIM.
    trava = 1'b1;
    envia(mk(1, 2, 1, 4, 5, 6), 1'b1);
    ciclos = 0;
    while (bus.novoDado !== 1'b1 && ciclos < 100) begin
      @(negedge clock);
      ciclos++;
    end
    ciclos = 0;
    while (erroTimeout !== 1'b1 && ciclos < 100) begin
      @(negedge clock);
      ciclos++;
    end
    chk("timeout_ciclos", 32'(ciclos), 32'd23);
    chk("timeout_novoDado", 32'(bus.novoDado), 32'd0);
    trava = 1'b0;
    espera_ocioso("ocioso_timeout");
    chk("timeout_leituras", 32'(contadorLeituras), 32'(leit_esp));
    envia(mk(3, 3, 0, 7, 8, 9), 1'b1);
    espera_ocioso("ocioso_pos_timeout");
    leit_esp += 1;
    chk("pos_timeout_leituras", 32'(contadorLeituras), 32'(leit_esp));
    chk("erro_pegajoso", 32'(erroTimeout), 32'd1);

    // Reset in AGUARDA_FIM with two readings queued.
    trava = 1'b1;
    envia(mk(6, 1, 1, 1, 2, 3), 1'b1);
    ciclos = 0;
    while (!(ocupado === 1'b1 && bus.operacaoFinalizada === 1'b0) && ciclos < 100) begin
      @(negedge clock);
      ciclos++;
    end
    chk("aguarda_fim_alcancado", 32'(ciclos < 100), 32'd1);
    envia(mk(2, 2, 0, 4, 4, 4), 1'b0);
    envia(mk(4, 4, 1, 5, 5, 5), 1'b0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_meio_novoDado", 32'(bus.novoDado), 32'd0);
    chk("rst_meio_ocupado", 32'(ocupado), 32'd0);
    chk("rst_meio_pronta", 32'(bus.leituraPronta), 32'd1);
    chk("rst_meio_contadores", {contadorLeituras, contadorDescartes}, 32'd0);
    chk("rst_meio_erro", 32'(erroTimeout), 32'd0);
    chk("rst_meio_campos", 32'(saida_atual()), 32'd0);
    @(negedge clock) reset = 1'b0;
    trava = 1'b0;
    vistos = 0;
    repeat (10) begin
      @(negedge clock);
      if (ocupado !== 1'b0) vistos++;
    end
    chk("fila_vazia_pos_reset", 32'(vistos), 32'd0);
    envia(mk(5, 6, 0, 1, 0, 1), 1'b1);
    espera_ocioso("ocioso_final");
    chk("final_leituras", 32'(contadorLeituras), 32'd1);
    chk("scoreboard_vazio", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
